// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               size codes, FSM state encoding, byte-strobe and lane masks,
//               and the alignment-fault predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store size codes (stores use the low two bits only)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0]  STRB_NONE = 4'b0000;
  localparam logic [3:0]  STRB_B    = 4'b0001;
  localparam logic [3:0]  STRB_H_LO = 4'b0011;
  localparam logic [3:0]  STRB_H_HI = 4'b1100;
  localparam logic [3:0]  STRB_W    = 4'b1111;

  localparam logic [31:0] MASK_B    = 32'h0000_00FF;
  localparam logic [31:0] MASK_H    = 32'h0000_FFFF;

  // Unsupported size codes are folded into the alignment fault so the core
  // sees a single "access not performed" indication.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return a[0];
      F3_LW:         return (a != 2'b00);
      default:       return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_if_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_if_if
// Description : Bundle of the core-side request/response signals and the
//               handshaked data-memory port of the load/store unit.
//   master : LSU view (drives stall, rsp_*, mem_req/we/addr/wstrb/wdata)
//   slave  : environment view (core + memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_if_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 32
);
  // core side
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [WIDTH_ADDR-1:0] req_addr;
  logic [WIDTH_DATA-1:0] req_wdata;
  logic                  stall;
  logic                  rsp_valid;
  logic [WIDTH_DATA-1:0] rsp_rdata;
  logic                  misaligned;
  logic                  bus_err;
  // memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [WIDTH_ADDR-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [WIDTH_DATA-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [WIDTH_DATA-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output stall, rsp_valid, rsp_rdata, misaligned, bus_err,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, misaligned, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for the LSU.
//   funct3/addr_lo : access size and byte offset
//   st_data        : right-aligned store data -> wdata (replicated lanes), wstrb
//   ld_raw         : raw memory word -> ld_data (selected, sign/zero extended)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] w_shift;

  // Shift the addressed byte/half down to bit 0; halves are 2-byte aligned
  // by the time they get here, so addr_lo*8 is always 0 or 16 for them.
  assign w_shift = ld_raw >> {addr_lo, 3'b000};

  always_comb begin
    wstrb = STRB_W;
    wdata = st_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = STRB_B << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        wstrb = addr_lo[1] ? STRB_H_HI : STRB_H_LO;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        wstrb = STRB_W;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_data = ld_raw;
    case (funct3)
      F3_LB:   ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LBU:  ld_data = w_shift & MASK_B;
      F3_LHU:  ld_data = w_shift & MASK_H;
      default: ld_data = ld_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_if
// Description : Load/store unit turning a core access into a handshaked
//               memory transaction with sizing, alignment check, load
//               extension and response timeout. Stalls the core meanwhile.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : core request/response + data-memory port (master view)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int WIDTH_DATA     = 32,
  parameter int WIDTH_ADDR     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_mem_if_if.master bus
);

  localparam int              c_cnt_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  lsu_state_t            r_state, w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [WIDTH_DATA-1:0] r_wdata;
  logic                  r_misaligned;
  logic                  r_bus_err;
  logic [WIDTH_DATA-1:0] r_rdata;
  logic [c_cnt_w-1:0]    r_cnt;

  logic                  w_fault;
  logic                  w_timeout;
  logic                  w_load_done;
  logic                  w_to_err;
  logic                  w_in_req;
  logic                  w_store_drv;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_wdata;
  logic [31:0]           w_ld_data;

  lsu_align u_align (
    .funct3  (r_funct3),
    .addr_lo (r_addr[1:0]),
    .st_data (r_wdata),
    .ld_raw  (bus.mem_rdata),
    .wstrb   (w_wstrb),
    .wdata   (w_wdata),
    .ld_data (w_ld_data)
  );

  assign w_fault   = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign w_timeout = (r_cnt == c_cnt_last);

  // Load data arrives either together with the request handshake or later in WAIT.
  assign w_load_done = ((r_state == ST_REQ) && bus.mem_ready && !r_we && bus.mem_rvalid) ||
                       ((r_state == ST_WAIT) && bus.mem_rvalid);
  assign w_to_err    = w_timeout &&
                       (((r_state == ST_REQ) && !bus.mem_ready) ||
                        ((r_state == ST_WAIT) && !bus.mem_rvalid));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = w_fault ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (bus.mem_ready) w_next = (r_we || bus.mem_rvalid) ? ST_DONE : ST_WAIT;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_WAIT: if (bus.mem_rvalid || w_timeout) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && bus.req_valid) begin
        r_we         <= bus.req_we;
        r_funct3     <= bus.req_funct3;
        r_addr       <= bus.req_addr;
        r_wdata      <= bus.req_wdata;
        r_misaligned <= w_fault;
        r_bus_err    <= 1'b0;
        r_cnt        <= '0;
      end
      if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
        r_cnt     <= r_cnt + c_cnt_one;
        r_bus_err <= w_to_err;
      end
      // Response data only changes on entry to DONE; stores and faults report 0.
      if ((w_next == ST_DONE) && (r_state != ST_DONE))
        r_rdata <= w_load_done ? w_ld_data : '0;
    end
  end

  assign w_in_req    = (r_state == ST_REQ);
  assign w_store_drv = w_in_req && r_we;

  assign bus.stall      = (r_state == ST_IDLE) ? bus.req_valid
                                               : ((r_state == ST_REQ) || (r_state == ST_WAIT));
  assign bus.rsp_valid  = (r_state == ST_DONE);
  assign bus.misaligned = (r_state == ST_DONE) && r_misaligned;
  assign bus.bus_err    = (r_state == ST_DONE) && r_bus_err;
  assign bus.rsp_rdata  = r_rdata;

  assign bus.mem_req    = w_in_req;
  assign bus.mem_we     = w_store_drv;
  assign bus.mem_addr   = w_in_req ? {r_addr[WIDTH_ADDR-1:2], 2'b00} : '0;
  assign bus.mem_wstrb  = w_store_drv ? w_wstrb : STRB_NONE;
  assign bus.mem_wdata  = w_store_drv ? w_wdata : '0;

endmodule
`default_nettype wire
